// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, register offsets
// and STATUS register bit positions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_FRAME_ERR = 2;
  localparam int ST_OVERRUN   = 3;
  localparam int ST_PAR_ERR   = 4;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous DEPTH x 8 receive FIFO with extra-MSB pointers; a pop in the
// same cycle frees a slot so a push into a full FIFO still lands.
module rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push_ok;
  logic        pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_intr.sv
// Memory-mapped UART receiver with FIFO and level interrupt to the core.
// Define UART_RX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_rx_intr
  import uart_pkg::*;
#(
  parameter int DIV   = 434,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        sel,
  input  logic        addr,
  input  logic        re,
  output logic [15:0] rdata,
  output logic        uart_intr,
  output logic        rx_busy
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] MID  = CW'(DIV / 2);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic            rx_meta;
  logic            rxs;
  rx_state_t       state;
  rx_state_t       state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [2:0]      bit_idx;
  logic [2:0]      bit_next;
  logic [7:0]      shreg;
  logic [7:0]      shreg_next;
  logic            push;
  logic            frame_set;
  logic            overrun_set;
  logic            frame_err;
  logic            overrun;
  logic            par_err;
  logic            full;
  logic            empty;
  logic [7:0]      head;
  logic            rd_data;
  logic            rd_status;
  logic            pop;
  logic [15:0]     status_word;
`ifdef UART_RX_PARITY_EN
  logic            par_set;
`endif

  assign rd_data     = sel && re && (addr == REG_DATA);
  assign rd_status   = sel && re && (addr == REG_STATUS);
  assign pop         = rd_data && !empty;
  assign overrun_set = push && full && !pop;
  assign rx_busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shreg   <= shreg_next;
    end
  end

  // Start bit is checked at its mid-point; every later sample is DIV cycles on.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    bit_next   = bit_idx;
    shreg_next = shreg;
    push       = 1'b0;
    frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set    = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rxs) state_next = START;
      end
      START: begin
        if (cnt == MID) begin
          cnt_next = '0;
          bit_next = '0;
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_next   = '0;
          shreg_next = {rxs, shreg[7:1]};
          bit_next   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt == LAST) begin
          cnt_next   = '0;
          par_set    = (rxs != ^shreg);
          state_next = STOP;
        end
`else
        state_next = IDLE;
`endif
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_next   = '0;
          push       = rxs;
          frame_set  = !rxs;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (shreg),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    status_word               = '0;
    status_word[ST_NOT_EMPTY] = !empty;
    status_word[ST_FULL]      = full;
    status_word[ST_FRAME_ERR] = frame_err;
    status_word[ST_OVERRUN]   = overrun;
    status_word[ST_PAR_ERR]   = par_err;
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset) par_err <= 1'b0;
    else        par_err <= par_set || (par_err && !rd_status);
  end
`else
  assign par_err = 1'b0;
`endif

  // A STATUS read clears sticky flags unless a new event sets them that cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      uart_intr <= 1'b0;
      rdata     <= '0;
    end else begin
      frame_err <= frame_set || (frame_err && !rd_status);
      overrun   <= overrun_set || (overrun && !rd_status);
      uart_intr <= !empty;
      if (rd_data)        rdata <= empty ? 16'h0000 : {8'h00, head};
      else if (rd_status) rdata <= status_word;
    end
  end

endmodule

// File: doc/uart_rx_intr.md
Name: uart_rx_intr

Overview:
Memory-mapped UART receiver that sits upstream of the cpu core.
- Deserialises the rx pin into bytes and buffers them in a small FIFO.
- Drives the level interrupt that feeds the core's UART_intr input.
- The core reads data and status through two word registers, selected by an external address decode.

Parameters:
DIV, 434, clk cycles per bit (50 MHz / 115200); must be >= 4
DEPTH, 8, FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low (0 = reset)
rx  in  1  asynchronous serial input, idle high
sel  in  1  address decode hit for this block
addr  in  1  0 = DATA register, 1 = STATUS register
re  in  1  cpu read strobe, qualified with sel
rdata  out  16  registered read data
uart_intr  out  1  level interrupt to the core
rx_busy  out  1  frame reception in progress

Behaviour:
- Reset (reset==0 on a clk edge): FSM to IDLE, FIFO empty, sticky flags cleared.
  - rdata=0x0000, uart_intr=0, rx_busy=0.
  - Synchroniser flops set to 1.
  - Reset has priority over every other event and aborts a frame mid-reception; that partial byte is lost.
- rx synchronisation: 2-flop synchroniser; rxs is the second-stage value. All sampling uses rxs.
- Bit counter: counts 0..DIV-1 then wraps. A second counter tracks bit index 0..7.
- IDLE: rx_busy=0. On rxs==0, go to START and clear the counter.
- START: at count DIV/2 (integer division), sample rxs.
  - 0: valid start bit. Realign to mid-bit, go to DATA.
  - 1: glitch. Return to IDLE with no flag set.
- DATA: sample every DIV cycles from the start-bit mid-point. LSB first, 8 bits. After bit 7, go to STOP.
- STOP: sample once after DIV cycles.
  - rxs==1: push byte into FIFO.
  - rxs==0: set sticky frame_err, discard byte.
  - Either way return to IDLE; rx_busy drops the same cycle.
- rx_busy=1 in START, DATA and STOP.
- Push when FIFO full: byte dropped, sticky overrun set.
  - Exception: a pop in the same cycle frees a slot, so the push succeeds and overrun is not set.
- DATA read (sel&&re&&addr==0): rdata={8'h00, head byte} on the next edge, then pop. Read of an empty FIFO returns 0x0000; pointers unchanged.
- STATUS read (sel&&re&&addr==1): rdata={11'b0, par_err, overrun, frame_err, full, !empty}.
  - Sticky bits are captured into rdata, then cleared on the same edge.
  - A flag-setting event in that same cycle wins: the flag stays set.
- rdata holds its value when no read occurs. Read latency is 1 cycle.
- uart_intr = registered !empty. It rises 1 cycle after the push edge and falls 1 cycle after the pop that empties the FIFO.
- FIFO pointers are log2(DEPTH)+1 bits, with wrap-around by natural overflow.
  - full: MSBs differ, remaining bits equal.
  - empty: pointers equal.

Optional Feature:
UART_RX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP; one even-parity bit is sampled at DIV.
  - Mismatch sets sticky par_err (STATUS bit 4); the byte is still pushed if the stop bit is good.
- Undefined: no PARITY state; STATUS bit 4 reads 0.

Decomposition:
- Package uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP), register offsets (REG_DATA=0, REG_STATUS=1), STATUS bit positions.
- Sub-module rx_fifo, a synchronous DEPTH x 8 FIFO, instantiated once.
  - Ports: push, pop, wdata, rdata, full, empty.

Test Plan:
- Basic byte: DIV=16, send 0xA5 with a good stop bit.
  - uart_intr=1 one cycle after the STOP sample.
  - DATA read gives rdata=0x00A5 next cycle; uart_intr=0 one cycle later.
- Glitch: pull rx low for DIV/2-1 cycles.
  - FSM returns to IDLE, no push, STATUS=0x0000.
- Frame error: send 0x3C with stop bit 0.
  - FIFO stays empty, STATUS read=0x0004.
  - A second STATUS read returns 0x0000.
- Overrun: send DEPTH+1 bytes 0x01..0x09 without reading.
  - STATUS=0x000B (overrun, full, !empty).
  - Reading the FIFO out yields 0x01..0x08, then 0x0000 on the empty read.
- Full with simultaneous pop: with the FIFO full, pop in the same cycle as a push.
  - No overrun; the last byte read equals the new byte.
- Reset mid-frame: reset low during DATA bit 4.
  - All outputs 0, rx_busy=0.
  - The next clean byte 0x5A is received correctly.
